// File: rtl/hardmax_finder.sv
// Captures a packed vector of neuron outputs and scans it one element per cycle,
// reporting the index and value of the largest signed element (ties keep the lower index).
module hardmax_finder #(
    parameter int numInput   = 10,
    parameter int dataWidth  = 16,
    parameter int indexWidth = $clog2(numInput)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numInput*dataWidth-1:0] i_data,
    input  logic                          i_valid,
    output logic [indexWidth-1:0]         o_data,
    output logic [dataWidth-1:0]          o_max_value,
    output logic                          o_data_valid,
    output logic                          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int CNT_W = indexWidth + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numInput - 1);

    state_t                        state_q, state_d;
    logic [numInput*dataWidth-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [dataWidth-1:0]          max_q, max_d;
    logic [indexWidth-1:0]         idx_q, idx_d;
    logic [indexWidth-1:0]         o_data_q, o_data_d;
    logic [dataWidth-1:0]          o_max_q, o_max_d;
    logic                          o_vld_q, o_vld_d;
    logic                          busy_q, busy_d;

    logic [dataWidth-1:0]          elem;
    logic [dataWidth-1:0]          next_max;
    logic [indexWidth-1:0]         next_idx;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        idx_d    = idx_q;
        o_data_d = o_data_q;
        o_max_d  = o_max_q;
        o_vld_d  = 1'b0;
        busy_d   = busy_q;

        // Counter never exceeds numInput-1, so its low bits address the buffer directly.
        elem     = buf_q[cnt_q[indexWidth-1:0]*dataWidth +: dataWidth];
        next_max = max_q;
        next_idx = idx_q;
        if ($signed(elem) > $signed(max_q)) begin
            next_max = elem;
            next_idx = cnt_q[indexWidth-1:0];
        end

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    buf_d   = i_data;
                    max_d   = i_data[dataWidth-1:0];
                    idx_d   = '0;
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                max_d = next_max;
                idx_d = next_idx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    o_data_d = next_idx;
                    o_max_d  = next_max;
                    o_vld_d  = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            o_data_q <= '0;
            o_max_q  <= '0;
            o_vld_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            o_data_q <= o_data_d;
            o_max_q  <= o_max_d;
            o_vld_q  <= o_vld_d;
            busy_q   <= busy_d;
        end
    end

    assign o_data       = o_data_q;
    assign o_max_value  = o_max_q;
    assign o_data_valid = o_vld_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hardmax_finder.sv
// Bench for hardmax_finder: directed scenarios plus random vectors against an argmax reference.
module tb_hardmax_finder;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  i_data;
    logic            i_valid;
    logic [IW-1:0]   o_data;
    logic [W-1:0]    o_max_value;
    logic            o_data_valid;
    logic            busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hardmax_finder #(.numInput(N), .dataWidth(W)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data), .o_max_value(o_max_value),
        .o_data_valid(o_data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Argmax over signed elements; first occurrence wins on ties.
    function automatic void ref_max(input logic [N*W-1:0] v, output int idx, output logic [W-1:0] mx);
        logic [W-1:0] e;
        mx  = v[W-1:0];
        idx = 0;
        for (int k = 1; k < N; k++) begin
            e = v[k*W +: W];
            if ($signed(e) > $signed(mx)) begin
                mx  = e;
                idx = k;
            end
        end
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] val);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = val;
        return v;
    endfunction

    task automatic capture(input logic [N*W-1:0] v);
        i_data  = v;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = {N*W{1'b1}};
    endtask

    // Cycles after the capture edge until o_data_valid is seen; -1 on timeout.
    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_data_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic send_check(input string name, input logic [N*W-1:0] v);
        int lat, eidx;
        logic [W-1:0] emax;
        ref_max(v, eidx, emax);
        capture(v);
        wait_pulse(lat);
        total_cnt++;
        if (lat !== N - 1) $display("FAIL %s latency: got %0d expected %0d", name, lat, N - 1);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== IW'(eidx)) $display("FAIL %s index: got %0d expected %0d", name, o_data, eidx);
        else pass_cnt++;
        total_cnt++;
        if (o_max_value !== emax) $display("FAIL %s value: got %h expected %h", name, o_max_value, emax);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; i_data = '0;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if ({o_data_valid, busy} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {o_data_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if (o_data !== '0 || o_max_value !== '0)
            $display("FAIL reset_outputs: got idx %0d val %h expected 0 0000", o_data, o_max_value);
        else pass_cnt++;
    endtask

    task automatic test_ascending;
        logic [N*W-1:0] v;
        int bad = 0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k);
        capture(v);
        if (busy !== 1'b1) bad++;
        for (int c = 1; c < N - 1; c++) begin
            tick();
            if (busy !== 1'b1 || o_data_valid !== 1'b0) bad++;
        end
        tick();
        total_cnt++;
        if (o_data_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL asc_pulse: got vld %b busy %b expected 1 0", o_data_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL asc_busy_window: got %0d bad cycles expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== IW'(9) || o_max_value !== 16'd9)
            $display("FAIL asc_result: got idx %0d val %h expected 9 0009", o_data, o_max_value);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (o_data_valid !== 1'b0 || o_data !== IW'(9))
            $display("FAIL asc_single_pulse_hold: got vld %b idx %0d expected 0 9", o_data_valid, o_data);
        else pass_cnt++;
    endtask

    task automatic test_ties;
        logic [N*W-1:0] v;
        v = fill(16'h0010);
        v[3*W +: W] = 16'h0100;
        v[7*W +: W] = 16'h0100;
        send_check("ties", v);
        total_cnt++;
        if (o_data !== IW'(3)) $display("FAIL ties_lower_index: got %0d expected 3", o_data);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        logic [N*W-1:0] v;
        v = fill(16'h8000);
        v[4*W +: W] = 16'hFFFF;
        v[6*W +: W] = 16'h8001;
        send_check("signed_neg", v);
        total_cnt++;
        if (o_data !== IW'(4) || o_max_value !== 16'hFFFF)
            $display("FAIL signed_neg_direct: got idx %0d val %h expected 4 ffff", o_data, o_max_value);
        else pass_cnt++;
        v[2*W +: W] = 16'h7FFF;
        send_check("signed_pos", v);
        total_cnt++;
        if (o_data !== IW'(2) || o_max_value !== 16'h7FFF)
            $display("FAIL signed_pos_direct: got idx %0d val %h expected 2 7fff", o_data, o_max_value);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [N*W-1:0] v;
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < N; k++) begin
                if (t % 2 == 0) v[k*W +: W] = W'($urandom);
                else            v[k*W +: W] = W'($urandom_range(0, 3)) - 16'd2;
            end
            send_check($sformatf("random%0d", t), v);
        end
    endtask

    task automatic test_dropped;
        logic [N*W-1:0] a, b;
        int pulses = 0, first = -1, early = 0;
        a = fill(16'h0001); a[5*W +: W] = 16'h0050;
        b = fill(16'h0002); b[1*W +: W] = 16'h0700;
        capture(a);
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin i_data = b; i_valid = 1'b1; end
            tick();
            i_valid = 1'b0;
            if (o_data_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (first < 0 && busy !== 1'b1) early++;
        end
        total_cnt++;
        if (pulses !== 1) $display("FAIL drop_pulse_count: got %0d expected 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if (first !== N - 1) $display("FAIL drop_latency: got %0d expected %0d", first, N - 1);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== IW'(5) || o_max_value !== 16'h0050)
            $display("FAIL drop_result: got idx %0d val %h expected 5 0050", o_data, o_max_value);
        else pass_cnt++;
        total_cnt++;
        if (early !== 0) $display("FAIL drop_busy_early: got %0d cycles expected 0", early);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [N*W-1:0] a, b;
        int lat, ai, bi, hold_bad = 0;
        logic [W-1:0] am, bm;
        for (int k = 0; k < N; k++) begin
            a[k*W +: W] = W'($urandom);
            b[k*W +: W] = W'($urandom);
        end
        ref_max(a, ai, am);
        ref_max(b, bi, bm);
        capture(a);
        wait_pulse(lat);
        total_cnt++;
        if (lat !== N - 1 || o_data !== IW'(ai) || o_max_value !== am)
            $display("FAIL b2b_first: got lat %0d idx %0d val %h expected %0d %0d %h",
                     lat, o_data, o_max_value, N - 1, ai, am);
        else pass_cnt++;
        capture(b);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            if (o_data !== IW'(ai) || o_max_value !== am) hold_bad++;
            tick();
            if (o_data_valid === 1'b1) begin lat = c; break; end
        end
        total_cnt++;
        if (lat !== N - 1) $display("FAIL b2b_latency: got %0d expected %0d", lat, N - 1);
        else pass_cnt++;
        total_cnt++;
        if (hold_bad !== 0) $display("FAIL b2b_hold: got %0d bad cycles expected 0", hold_bad);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== IW'(bi) || o_max_value !== bm)
            $display("FAIL b2b_second: got idx %0d val %h expected %0d %h", o_data, o_max_value, bi, bm);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [N*W-1:0] v;
        int pulses = 0;
        v = fill(16'h0003); v[8*W +: W] = 16'h0042;
        capture(v);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (o_data !== '0 || o_max_value !== '0 || busy !== 1'b0 || o_data_valid !== 1'b0)
            $display("FAIL rstmid_state: got idx %0d val %h busy %b vld %b expected 0 0000 0 0",
                     o_data, o_max_value, busy, o_data_valid);
        else pass_cnt++;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (o_data_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", pulses);
        else pass_cnt++;
        v[8*W +: W] = 16'h0001;
        v[6*W +: W] = 16'h0123;
        send_check("rstmid_fresh", v);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0;
        test_reset();
        test_ascending();
        test_ties();
        test_signed();
        test_dropped();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hardmax_finder.md
Name: hardmax_finder

Overview:
- Final-layer post-processing stage, directly downstream of the last layer's neuron array.
- Captures the packed vector of all numInput neuron outputs on a valid strobe.
- Scans the vector sequentially, one element per cycle, and reports the index and value of the largest element as the network's classification result.
- Signed (two's complement) comparison.

Parameters:
numInput, 10, number of neuron outputs in the vector; legal range 2..256
dataWidth, 16, width of each neuron output, two's complement
indexWidth, $clog2(numInput), width of the result index (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  reset
i_data  input  numInput*dataWidth  packed neuron outputs; element k occupies bits [k*dataWidth +: dataWidth]
i_valid  input  1  one-cycle strobe; i_data valid this cycle
o_data  output  indexWidth  index of maximum element
o_max_value  output  dataWidth  value of maximum element
o_data_valid  output  1  one-cycle pulse; o_data/o_max_value updated
busy  output  1  high while a scan is in progress

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state=IDLE, busy=0, o_data_valid=0, o_data=0, o_max_value=0, counter=0, capture buffer=0.
- Reset mid-scan aborts the scan. No o_data_valid pulse is produced, and outputs return to their reset values.

- FSM: two states, IDLE and SCAN.

- IDLE:
  - On an edge with i_valid=1: register all of i_data into the capture buffer.
  - Same edge: running max <= element 0, running index <= 0, counter <= 1, busy <= 1, state <= SCAN.
  - With i_valid=0: hold all state.

- SCAN: each edge compares buffer[counter] against the running max, signed.
  - If strictly greater: running max <= element, running index <= counter.
  - Ties keep the earlier (lower) index.
  - Counter increments by 1 per edge.
  - On the edge processing element numInput-1:
    - o_data <= final index, o_max_value <= final max (including that element's compare result).
    - o_data_valid <= 1, busy <= 0, state <= IDLE.

- Latency: with capture at edge T, o_data_valid is high during the cycle after edge T+numInput-1. That is exactly numInput-1 cycles after capture (9 for the default).
- Throughput: one vector per numInput cycles.

- o_data_valid is high for exactly one cycle.
- o_data and o_max_value hold their last result until the next result; they are never cleared except by rst.

- i_valid while busy=1 (state SCAN): ignored and dropped. The capture buffer is not disturbed and the running scan is unaffected.
- i_valid in the same cycle o_data_valid is high: state is IDLE, so the new vector is accepted (back-to-back operation).
- The capture buffer isolates the scan from i_data changes after capture; upstream need not hold i_data.

- Counter width: indexWidth+1 bits, so numInput-1 is representable without wrap. The counter never exceeds numInput-1.
- Comparison uses $signed on dataWidth bits. Most negative vs most positive values are ordered correctly.

Test Plan:
1. Ascending vector, element k = k (0..9), i_valid at edge T -> o_data_valid pulses once after edge T+9; o_data=9, o_max_value=9; busy high from T through T+8.
2. Ties: element 3 = element 7 = 0x0100, all others 0x0010 -> o_data=3, o_max_value=0x0100.
3. Signed: all elements 0x8000 except element 4 = 0xFFFF (-1) and element 6 = 0x8001 -> o_data=4, o_max_value=0xFFFF. Repeat with element 2 = 0x7FFF -> o_data=2.
4. Dropped strobe: start vector A (max at index 5); pulse i_valid with vector B (max at index 1) three cycles later -> only one result, o_data=5; busy never deasserts early.
5. Back-to-back: assert i_valid with vector B in the cycle o_data_valid for A is high -> second pulse exactly 9 cycles later with B's result. Outputs hold A's result in between.
6. Reset mid-scan: assert rst for one cycle at counter=4 -> no o_data_valid pulse; o_data=0, o_max_value=0, busy=0. A fresh vector afterwards produces a correct result with normal latency.
